// File: rtl/bus_arbiter_pkg.sv
// Shared types and helpers for the round-robin system bus arbiter.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT_WAIT = 2'd1,
    ACTIVE     = 2'd2,
    RELEASE    = 2'd3
  } arbState_t;

  // Ceiling log2, never below 1 so index vectors always have a bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_priority_select.sv
// Combinational round-robin pick: rotate so lastIndex+1 is bit 0,
// take the lowest set bit, rotate the index back.
module rr_priority_select
  import bus_arbiter_pkg::*;
#(
  parameter int NR_OF_MASTERS = 4,
  parameter int IDX_W         = clog2(NR_OF_MASTERS)
) (
  input  logic [NR_OF_MASTERS-1:0] request,
  input  logic [IDX_W-1:0]         lastIndex,
  output logic [NR_OF_MASTERS-1:0] grant,
  output logic [IDX_W-1:0]         grantIndex,
  output logic                     anyRequest
);

  logic [NR_OF_MASTERS-1:0] rotated;
  logic [IDX_W-1:0]         hitPos;

  always_comb begin
    rotated = '0;
    for (int i = 0; i < NR_OF_MASTERS; i++)
      rotated[i] = request[IDX_W'((i + int'(lastIndex) + 1) % NR_OF_MASTERS)];
  end

  // Descending scan so the lowest set bit is the last one written.
  always_comb begin
    hitPos = '0;
    for (int i = NR_OF_MASTERS - 1; i >= 0; i--)
      if (rotated[i]) hitPos = IDX_W'(i);
  end

  always_comb begin
    anyRequest = |request;
    grantIndex = IDX_W'((int'(hitPos) + int'(lastIndex) + 1) % NR_OF_MASTERS);
    grant      = '0;
    if (anyRequest) grant[grantIndex] = 1'b1;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin system bus arbiter with registered one-hot grant and a
// shared watchdog that terminates stalled grants and transactions.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NR_OF_MASTERS       = 4,
  parameter int GRANT_TIMEOUT       = 16,
  parameter int TRANSACTION_TIMEOUT = 4096,
  parameter int IDX_W               = clog2(NR_OF_MASTERS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NR_OF_MASTERS-1:0] requestBus,
  output logic [NR_OF_MASTERS-1:0] busGrant,
  input  logic                     beginTransactionIn,
  input  logic                     endTransactionIn,
  input  logic                     busErrorIn,
  output logic                     beginTransactionOut,
  output logic                     endTransactionOut,
  output logic                     busErrorOut,
  output logic [IDX_W-1:0]         activeMaster,
  output logic [7:0]               timeoutCount
);

  localparam int WD_MAX = (GRANT_TIMEOUT > TRANSACTION_TIMEOUT) ? GRANT_TIMEOUT : TRANSACTION_TIMEOUT;
  localparam int WD_W   = clog2(WD_MAX);
  localparam logic [WD_W-1:0] GRANT_LIMIT = WD_W'(GRANT_TIMEOUT - 1);
  localparam logic [WD_W-1:0] TXN_LIMIT   = WD_W'(TRANSACTION_TIMEOUT - 1);

  arbState_t state, stateNext;
  logic [WD_W-1:0]          watchdog;
  logic [NR_OF_MASTERS-1:0] selGrant, grantNext;
  logic [IDX_W-1:0]         selIndex, masterNext;
  logic                     anyRequest, errNext, endNext, timeoutHit;

  // Slave errors are the master's/slave's business; the arbiter only ends on the strobe.
  logic unusedBusError;
  assign unusedBusError = busErrorIn;

  assign beginTransactionOut = 1'b0;

  rr_priority_select #(
    .NR_OF_MASTERS(NR_OF_MASTERS),
    .IDX_W        (IDX_W)
  ) uSelect (
    .request   (requestBus),
    .lastIndex (activeMaster),
    .grant     (selGrant),
    .grantIndex(selIndex),
    .anyRequest(anyRequest)
  );

  always_comb begin
    stateNext  = state;
    grantNext  = busGrant;
    masterNext = activeMaster;
    errNext    = 1'b0;
    endNext    = 1'b0;
    timeoutHit = 1'b0;
    case (state)
      IDLE: begin
        if (anyRequest) begin
          grantNext  = selGrant;
          masterNext = selIndex;
          stateNext  = GRANT_WAIT;
        end
      end
      GRANT_WAIT: begin
        if (beginTransactionIn) begin
          stateNext = ACTIVE;
        end else if (watchdog == GRANT_LIMIT) begin
          errNext    = 1'b1;
          timeoutHit = 1'b1;
          grantNext  = '0;
          stateNext  = RELEASE;
        end
      end
      ACTIVE: begin
        if (endTransactionIn) begin
          grantNext = '0;
          stateNext = RELEASE;
        end else if (watchdog == TXN_LIMIT) begin
          errNext    = 1'b1;
          endNext    = 1'b1;
          timeoutHit = 1'b1;
          grantNext  = '0;
          stateNext  = RELEASE;
        end
      end
      RELEASE: begin
        grantNext = '0;
        stateNext = IDLE;
      end
      default: begin
        grantNext = '0;
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      busGrant          <= '0;
      activeMaster      <= IDX_W'(NR_OF_MASTERS - 1);
      busErrorOut       <= 1'b0;
      endTransactionOut <= 1'b0;
      timeoutCount      <= '0;
    end else begin
      state             <= stateNext;
      busGrant          <= grantNext;
      activeMaster      <= masterNext;
      busErrorOut       <= errNext;
      endTransactionOut <= endNext;
      if (timeoutHit && timeoutCount != 8'hFF) timeoutCount <= timeoutCount + 8'd1;
    end
  end

  // Cleared on every state change; saturates so a long IDLE never wraps it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                   watchdog <= '0;
    else if (stateNext != state) watchdog <= '0;
    else if (watchdog != '1)     watchdog <= watchdog + 1'b1;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: grants, watchdogs, async reset, fairness.
module tb_bus_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] requestBus;
  logic [3:0] busGrant;
  logic       beginTransactionIn, endTransactionIn, busErrorIn;
  logic       beginTransactionOut, endTransactionOut, busErrorOut;
  logic [1:0] activeMaster;
  logic [7:0] timeoutCount;

  int checks = 0;
  int errors = 0;

  bus_arbiter dut (
    .clock              (clock),
    .reset              (reset),
    .requestBus         (requestBus),
    .busGrant           (busGrant),
    .beginTransactionIn (beginTransactionIn),
    .endTransactionIn   (endTransactionIn),
    .busErrorIn         (busErrorIn),
    .beginTransactionOut(beginTransactionOut),
    .endTransactionOut  (endTransactionOut),
    .busErrorOut        (busErrorOut),
    .activeMaster       (activeMaster),
    .timeoutCount       (timeoutCount)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; requestBus = '0;
    beginTransactionIn = 0; endTransactionIn = 0; busErrorIn = 0;
    tick(); tick();
    checks++; if (busGrant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", busGrant); end
    checks++; if (activeMaster !== 2'd3) begin errors++; $display("FAIL reset_master got %0d want 3", activeMaster); end
    checks++; if ({busErrorOut, endTransactionOut, beginTransactionOut} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b want 000", {busErrorOut, endTransactionOut, beginTransactionOut}); end
    checks++; if (timeoutCount !== 8'd0) begin errors++; $display("FAIL reset_tocount got %0d want 0", timeoutCount); end
    reset = 1'b0;
  endtask

  task automatic test_alternate();
    requestBus = 4'b0101;
    tick();
    checks++; if (busGrant !== 4'b0001) begin errors++; $display("FAIL alt_first got %b want 0001", busGrant); end
    beginTransactionIn = 1; tick(); beginTransactionIn = 0;
    repeat (19) tick();
    checks++; if (busGrant !== 4'b0001) begin errors++; $display("FAIL alt_hold got %b want 0001", busGrant); end
    endTransactionIn = 1; tick(); endTransactionIn = 0;
    checks++; if (busGrant !== 4'b0000) begin errors++; $display("FAIL alt_release got %b want 0000", busGrant); end
    tick();
    checks++; if (busGrant !== 4'b0000) begin errors++; $display("FAIL alt_gap got %b want 0000", busGrant); end
    tick();
    checks++; if (busGrant !== 4'b0100 || activeMaster !== 2'd2) begin errors++; $display("FAIL alt_second got %b/%0d want 0100/2", busGrant, activeMaster); end
    beginTransactionIn = 1; tick(); beginTransactionIn = 0;
    endTransactionIn = 1; tick(); endTransactionIn = 0;
    tick(); tick();
    checks++; if (busGrant !== 4'b0001) begin errors++; $display("FAIL alt_third got %b want 0001", busGrant); end
    requestBus = '0;
    beginTransactionIn = 1; tick(); beginTransactionIn = 0;
    endTransactionIn = 1; tick(); endTransactionIn = 0;
    tick();
  endtask

  task automatic test_request_drop();
    requestBus = 4'b1000; tick(); requestBus = '0;
    checks++; if (busGrant !== 4'b1000) begin errors++; $display("FAIL drop_grant got %b want 1000", busGrant); end
    tick(); tick(); tick();
    checks++; if (busGrant !== 4'b1000) begin errors++; $display("FAIL drop_held got %b want 1000", busGrant); end
    beginTransactionIn = 1; tick(); beginTransactionIn = 0;
    checks++; if (busGrant !== 4'b1000 || activeMaster !== 2'd3) begin errors++; $display("FAIL drop_active got %b/%0d want 1000/3", busGrant, activeMaster); end
    endTransactionIn = 1; tick(); endTransactionIn = 0;
    tick();
  endtask

  task automatic test_grant_timeout();
    int hit;
    hit = -1;
    requestBus = 4'b0010; tick(); requestBus = 4'b0100;
    checks++; if (busGrant !== 4'b0010) begin errors++; $display("FAIL gto_grant got %b want 0010", busGrant); end
    for (int n = 1; n <= 40 && hit < 0; n++) begin
      tick();
      if (busErrorOut) hit = n;
    end
    checks++; if (hit !== 16) begin errors++; $display("FAIL gto_latency got %0d want 16", hit); end
    checks++; if (busGrant !== 4'b0000 || timeoutCount !== 8'd1) begin errors++; $display("FAIL gto_clear got %b/%0d want 0000/1", busGrant, timeoutCount); end
    tick();
    checks++; if (busErrorOut !== 1'b0 || busGrant !== 4'b0000) begin errors++; $display("FAIL gto_pulse got %b/%b want 0/0000", busErrorOut, busGrant); end
    tick();
    checks++; if (busGrant !== 4'b0100) begin errors++; $display("FAIL gto_next got %b want 0100", busGrant); end
    requestBus = '0;
  endtask

  task automatic test_txn_timeout();
    int hit;
    hit = -1;
    beginTransactionIn = 1;
    for (int n = 1; n <= 5000 && hit < 0; n++) begin
      tick();
      beginTransactionIn = 0;
      if (busErrorOut) hit = n;
    end
    checks++; if (hit !== 4097) begin errors++; $display("FAIL tto_latency got %0d want 4097", hit); end
    checks++; if (endTransactionOut !== 1'b1 || busGrant !== 4'b0000 || timeoutCount !== 8'd2) begin errors++; $display("FAIL tto_pulse got %b/%b/%0d want 1/0000/2", endTransactionOut, busGrant, timeoutCount); end
    tick();
    checks++; if ({endTransactionOut, busErrorOut} !== 2'b00) begin errors++; $display("FAIL tto_one_cycle got %b want 00", {endTransactionOut, busErrorOut}); end
    tick();
  endtask

  task automatic test_begin_in_idle();
    beginTransactionIn = 1; tick(); beginTransactionIn = 0;
    checks++; if (busGrant !== 4'b0000) begin errors++; $display("FAIL idle_begin got %b want 0000", busGrant); end
    requestBus = 4'b0001; tick();
    checks++; if (busGrant !== 4'b0001) begin errors++; $display("FAIL idle_begin_grant got %b want 0001", busGrant); end
  endtask

  task automatic test_async_reset();
    beginTransactionIn = 1; tick(); beginTransactionIn = 0;
    #3 reset = 1'b1;
    #1;
    checks++; if (busGrant !== 4'b0000 || timeoutCount !== 8'd0 || endTransactionOut !== 1'b0) begin errors++; $display("FAIL areset got %b/%0d/%b want 0000/0/0", busGrant, timeoutCount, endTransactionOut); end
    @(posedge clock); #1;
    reset = 1'b0; requestBus = 4'b1111;
    tick();
    checks++; if (busGrant !== 4'b0001 || activeMaster !== 2'd0) begin errors++; $display("FAIL areset_first got %b/%0d want 0001/0", busGrant, activeMaster); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] want;
    for (int i = 0; i < 40; i++) begin
      want = 4'b0001 << (i % 4);
      checks++; if (busGrant !== want) begin errors++; $display("FAIL rr_grant txn %0d got %b want %b", i, busGrant, want); end
      beginTransactionIn = 1; tick(); beginTransactionIn = 0;
      endTransactionIn = 1; tick(); endTransactionIn = 0;
      checks++; if (busGrant !== 4'b0000) begin errors++; $display("FAIL rr_gap1 txn %0d got %b want 0000", i, busGrant); end
      tick();
      checks++; if (busGrant !== 4'b0000) begin errors++; $display("FAIL rr_gap2 txn %0d got %b want 0000", i, busGrant); end
      tick();
    end
    requestBus = '0;
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_request_drop();
    test_grant_timeout();
    test_txn_timeout();
    test_begin_in_idle();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
